// File: rtl/issue_scoreboard.sv
// Single-entry issue stage between decode and execute: holds one decoded instruction,
// tracks pending GPR/FPR writes in busy tables and stalls issue on RAW/WAW hazards.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// EMPTY    | holding register invalid, decode may be accepted
// WAIT_HAZ | held instruction blocked by a busy source/destination register
// WAIT_DS  | held instruction hazard-free, offered downstream
module issue_scoreboard #(
   parameter int INST_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  dec_valid,
   output logic                  dec_ready,
   input  logic [INST_W-1:0]     dec_inst,
   input  logic [REG_ADDR_W-1:0] dec_rd,
   input  logic [REG_ADDR_W-1:0] dec_rs,
   input  logic [REG_ADDR_W-1:0] dec_rt,
   input  logic                  dec_d_from_gpr,
   input  logic                  dec_d_from_fpr,
   input  logic                  dec_s_from_gpr,
   input  logic                  dec_s_from_fpr,
   input  logic                  dec_t_from_gpr,
   input  logic                  dec_t_from_fpr,
   input  logic                  dec_d_to_gpr,
   input  logic                  dec_d_to_fpr,
   output logic                  iss_valid,
   input  logic                  iss_ready,
   output logic [INST_W-1:0]     iss_inst,
   input  logic                  wb_gpr_en,
   input  logic [REG_ADDR_W-1:0] wb_gpr_addr,
   input  logic                  wb_fpr_en,
   input  logic [REG_ADDR_W-1:0] wb_fpr_addr,
   input  logic                  flush,
   output logic [CNT_W-1:0]      stall_cnt
);
   localparam int NREG = 2**REG_ADDR_W;

   typedef enum logic [1:0] {EMPTY, WAIT_HAZ, WAIT_DS} state_t;

   typedef struct packed {
      logic [INST_W-1:0]     inst;
      logic [REG_ADDR_W-1:0] rd;
      logic [REG_ADDR_W-1:0] rs;
      logic [REG_ADDR_W-1:0] rt;
      logic                  d_from_gpr;
      logic                  d_from_fpr;
      logic                  s_from_gpr;
      logic                  s_from_fpr;
      logic                  t_from_gpr;
      logic                  t_from_fpr;
      logic                  d_to_gpr;
      logic                  d_to_fpr;
   } entry_t;

   state_t           state_q, state_d;
   entry_t           h_q, h_d, dec_entry;
   logic [NREG-1:0]  gpr_busy_q, gpr_busy_d;
   logic [NREG-1:0]  fpr_busy_q, fpr_busy_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             h_valid, h_valid_d, fire, accept;

   function automatic logic hazard_f(input entry_t e, input logic [NREG-1:0] gb,
                                     input logic [NREG-1:0] fb);
      logic raw, waw;
      raw = (e.d_from_gpr && gb[e.rd]) || (e.d_from_fpr && fb[e.rd]) ||
            (e.s_from_gpr && gb[e.rs]) || (e.s_from_fpr && fb[e.rs]) ||
            (e.t_from_gpr && gb[e.rt]) || (e.t_from_fpr && fb[e.rt]);
      waw = (e.d_to_gpr && gb[e.rd]) || (e.d_to_fpr && fb[e.rd]);
      return raw || waw;
   endfunction

   assign dec_entry = '{inst: dec_inst, rd: dec_rd, rs: dec_rs, rt: dec_rt,
                        d_from_gpr: dec_d_from_gpr, d_from_fpr: dec_d_from_fpr,
                        s_from_gpr: dec_s_from_gpr, s_from_fpr: dec_s_from_fpr,
                        t_from_gpr: dec_t_from_gpr, t_from_fpr: dec_t_from_fpr,
                        d_to_gpr: dec_d_to_gpr, d_to_fpr: dec_d_to_fpr};

   assign h_valid   = (state_q != EMPTY);
   assign iss_inst  = h_q.inst;
   assign stall_cnt = stall_cnt_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= EMPTY;
         h_q         <= '0;
         gpr_busy_q  <= '0;
         fpr_busy_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         h_q         <= h_d;
         gpr_busy_q  <= gpr_busy_d;
         fpr_busy_q  <= fpr_busy_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      iss_valid = (state_q == WAIT_DS) && !flush;
      fire      = iss_valid && iss_ready;
      dec_ready = !flush && (!h_valid || fire);
      accept    = dec_valid && dec_ready;

      h_valid_d = h_valid;
      h_d       = h_q;
      if (flush) begin
         h_valid_d = 1'b0;
      end else if (accept) begin
         h_valid_d = 1'b1;
         h_d       = dec_entry;
      end else if (fire) begin
         h_valid_d = 1'b0;
      end

      // Clear first so a same-cycle set of the same register wins.
      gpr_busy_d = gpr_busy_q;
      fpr_busy_d = fpr_busy_q;
      if (wb_gpr_en) gpr_busy_d[wb_gpr_addr] = 1'b0;
      if (wb_fpr_en) fpr_busy_d[wb_fpr_addr] = 1'b0;
      if (fire && h_q.d_to_gpr) gpr_busy_d[h_q.rd] = 1'b1;
      if (fire && h_q.d_to_fpr) fpr_busy_d[h_q.rd] = 1'b1;
      gpr_busy_d[0] = 1'b0;

      // Next state classifies next cycle's entry against next cycle's busy bits.
      state_d = EMPTY;
      if (h_valid_d) state_d = hazard_f(h_d, gpr_busy_d, fpr_busy_d) ? WAIT_HAZ : WAIT_DS;

      stall_cnt_d = stall_cnt_q;
      if (state_q == WAIT_HAZ && stall_cnt_q != '1)
         stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end
endmodule
